// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit-adjust constants and a width helper.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD       = 4'd3;

    // Bits needed to hold values 0 .. value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Operand and result handshake bundle for bin_to_bcd_seq.
// The slave modport is the converter side, master is the producer/consumer side.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      binary;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;

    modport master (
        output in_valid, binary, out_ready,
        input  in_ready, out_valid, bcd, blank, overflow
    );

    modport slave (
        input  in_valid, binary, out_ready,
        output in_ready, out_valid, bcd, blank, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    // Digits never exceed 9 here, so the 4-bit sum cannot wrap.
    assign adjusted = (digit >= BCD_ADJ_THRESHOLD) ? (digit + BCD_ADJ_ADD) : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with overflow detection and a leading-zero blanking mask.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CW = (clog2(WIDTH + 1) < 1) ? 1 : clog2(WIDTH + 1);

    state_t                state_reg;
    logic [WIDTH-1:0]      shift_reg;
    logic [4*DIGITS-1:0]   acc_reg;
    logic [CW-1:0]         count_reg;
    logic                  overflow_reg;
    logic [DIGITS-1:0]     blank_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;

    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_next;
    logic                  overflow_next;
    logic [DIGITS-1:0]     blank_next;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (acc_reg[4*gi +: 4]),
                .adjusted (acc_adj[4*gi +: 4])
            );
        end
    endgenerate

    // The bit leaving the top digit would start a digit we do not have.
    assign acc_next      = {acc_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
    assign overflow_next = overflow_reg | acc_adj[4*DIGITS-1];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_ones
                assign blank_next[gi] = 1'b0;
            end else begin : g_upper
                assign blank_next[gi] = !overflow_next &&
                                        (acc_next[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            acc_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            blank_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_reg    <= bus.binary;
                        acc_reg      <= '0;
                        overflow_reg <= 1'b0;
                        blank_reg    <= '0;
                        count_reg    <= CW'(WIDTH);
                        in_ready_reg <= 1'b0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_reg      <= acc_next;
                    shift_reg    <= shift_reg << 1;
                    overflow_reg <= overflow_next;
                    count_reg    <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        blank_reg     <= blank_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.bcd       = acc_reg;
    assign bus.blank     = blank_reg;
    assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq in three configurations (8/3, 8/2, 16/5),
// checked every cycle against an arithmetic model plus literal spot checks.
module tb_bin_to_bcd_seq;

    localparam int NI          = 3;
    localparam int WS [NI]     = '{8, 8, 16};
    localparam int DS [NI]     = '{3, 2, 5};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid_s  [NI];
    logic        out_ready_s [NI];
    logic [15:0] binary_s    [NI];
    int          in_ready_s  [NI];
    int          out_valid_s [NI];
    int          bcd_s       [NI];
    int          blank_s     [NI];
    int          ovf_s       [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            bin_to_bcd_seq_if #(.WIDTH(WS[gi]), .DIGITS(DS[gi])) bus ();

            assign bus.in_valid    = in_valid_s[gi];
            assign bus.binary      = binary_s[gi][WS[gi]-1:0];
            assign bus.out_ready   = out_ready_s[gi];
            assign in_ready_s[gi]  = int'(bus.in_ready);
            assign out_valid_s[gi] = int'(bus.out_valid);
            assign bcd_s[gi]       = int'(bus.bcd);
            assign blank_s[gi]     = int'(bus.blank);
            assign ovf_s[gi]       = int'(bus.overflow);

            bin_to_bcd_seq #(.WIDTH(WS[gi]), .DIGITS(DS[gi])) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus)
            );
        end
    endgenerate

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: a pending operand becomes visible WIDTH edges after its accept edge.
    bit m_pending  [NI];
    int m_ready_at [NI];
    int m_val      [NI];
    bit m_zero     [NI];

    function automatic int pow10(input int d);
        int r;
        r = 1;
        for (int k = 0; k < d; k++) r = r * 10;
        return r;
    endfunction

    task automatic expected(input int i, input int v, output int e_bcd,
                            output int e_blank, output int e_ovf);
        int m;
        int low;
        m       = pow10(DS[i]);
        e_ovf   = (v >= m) ? 1 : 0;
        low     = v % m;
        e_bcd   = 0;
        e_blank = 0;
        for (int k = 0; k < DS[i]; k++) begin
            e_bcd = e_bcd | (((low / pow10(k)) % 10) << (4 * k));
            if (k > 0 && e_ovf == 0 && (low / pow10(k)) == 0)
                e_blank = e_blank | (1 << k);
        end
    endtask

    task automatic check(input string name, input int actual, input int required);
        n_cmp = n_cmp + 1;
        if (actual !== required) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, actual, required);
        end
    endtask

    task automatic model_edge();
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_pending[i] = 1'b0;
                m_zero[i]    = 1'b1;
            end else if (!m_pending[i]) begin
                if (in_valid_s[i]) begin
                    m_pending[i]  = 1'b1;
                    m_ready_at[i] = cyc + WS[i];
                    m_val[i]      = int'(binary_s[i]) & ((1 << WS[i]) - 1);
                    m_zero[i]     = 1'b0;
                end
            end else if (cyc > m_ready_at[i] && out_ready_s[i]) begin
                m_pending[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        int e_bcd, e_blank, e_ovf;
        bit e_valid;
        for (int i = 0; i < NI; i++) begin
            e_valid = m_pending[i] && (cyc >= m_ready_at[i]);
            check($sformatf("u%0d.in_ready", i), in_ready_s[i], int'(!m_pending[i]));
            check($sformatf("u%0d.out_valid", i), out_valid_s[i], int'(e_valid));
            if (e_valid) begin
                expected(i, m_val[i], e_bcd, e_blank, e_ovf);
                check($sformatf("u%0d.bcd", i), bcd_s[i], e_bcd);
                check($sformatf("u%0d.blank", i), blank_s[i], e_blank);
                check($sformatf("u%0d.overflow", i), ovf_s[i], e_ovf);
            end else if (m_zero[i]) begin
                check($sformatf("u%0d.rst_bcd", i), bcd_s[i], 0);
                check($sformatf("u%0d.rst_blank", i), blank_s[i], 0);
                check($sformatf("u%0d.rst_overflow", i), ovf_s[i], 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic lit(input int i, input int e_bcd, input int e_blank, input int e_ovf);
        check($sformatf("lit u%0d out_valid", i), out_valid_s[i], 1);
        check($sformatf("lit u%0d bcd", i), bcd_s[i], e_bcd);
        check($sformatf("lit u%0d blank", i), blank_s[i], e_blank);
        check($sformatf("lit u%0d overflow", i), ovf_s[i], e_ovf);
        $display("u%0d result: bcd=%0h blank=%0b overflow=%0d", i, bcd_s[i], blank_s[i], ovf_s[i]);
    endtask

    task automatic conv(input int i, input int v, input int e_bcd, input int e_blank, input int e_ovf);
        binary_s[i]   = 16'(v);
        in_valid_s[i] = 1'b1;
        tick();
        in_valid_s[i] = 1'b0;
        repeat (WS[i] - 1) tick();
        check($sformatf("lit u%0d early_valid", i), out_valid_s[i], 0);
        tick();
        lit(i, e_bcd, e_blank, e_ovf);
        tick();
        check($sformatf("lit u%0d in_ready_after", i), in_ready_s[i], 1);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid_s[i]  = 1'b0;
            out_ready_s[i] = 1'b1;
            binary_s[i]    = '0;
            m_pending[i]   = 1'b0;
            m_ready_at[i]  = 0;
            m_val[i]       = 0;
            m_zero[i]      = 1'b0;
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("lit reset in_ready", in_ready_s[0], 1);
        check("lit reset out_valid", out_valid_s[0], 0);

        conv(0, 255, 'h255, 'b000, 0);
        conv(0,   0, 'h000, 'b110, 0);
        conv(0,   7, 'h007, 'b110, 0);

        conv(1,  99, 'h99, 'b00, 0);
        conv(1, 100, 'h00, 'b00, 1);
        conv(1, 255, 'h55, 'b00, 1);

        // Second operand held on in_valid while the first is converting.
        binary_s[2]   = 16'd65535;
        in_valid_s[2] = 1'b1;
        tick();
        binary_s[2]   = 16'd40000;
        repeat (16) tick();
        lit(2, 'h65535, 'b00000, 0);
        check("lit u2 in_ready_done", in_ready_s[2], 0);
        tick();
        check("lit u2 in_ready_release", in_ready_s[2], 1);
        tick();
        in_valid_s[2] = 1'b0;
        check("lit u2 in_ready_busy", in_ready_s[2], 0);
        repeat (16) tick();
        lit(2, 'h40000, 'b00000, 0);
        tick();

        // Backpressure in DONE.
        out_ready_s[0] = 1'b0;
        binary_s[0]    = 16'd123;
        in_valid_s[0]  = 1'b1;
        tick();
        in_valid_s[0]  = 1'b0;
        repeat (8) tick();
        lit(0, 'h123, 'b000, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            lit(0, 'h123, 'b000, 0);
            check("lit u0 stall in_ready", in_ready_s[0], 0);
        end
        out_ready_s[0] = 1'b1;
        tick();
        check("lit u0 released out_valid", out_valid_s[0], 0);
        check("lit u0 released in_ready", in_ready_s[0], 1);

        // Reset on the fourth shift edge discards the operand.
        binary_s[0]   = 16'd200;
        in_valid_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("lit midrst out_valid", out_valid_s[0], 0);
        check("lit midrst in_ready", in_ready_s[0], 1);
        check("lit midrst bcd", bcd_s[0], 0);
        check("lit midrst overflow", ovf_s[0], 0);
        repeat (12) tick();
        conv(0, 42, 'h042, 'b100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces the fixed 8-bit, 2-digit combinational converter on display and readout paths where wider operands (for example 16-bit GCD results) make a combinational chain too deep. It uses a valid/ready handshake on both sides, detects overflow when DIGITS is too small, and produces a leading-zero blanking mask for seven-segment drivers.

Parameters:
WIDTH, 8, binary operand width in bits (≥1)
DIGITS, 3, number of BCD digits produced; the full range of 8 bits needs 3 digits and of 16 bits needs 5 digits

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand present on binary
in_ready  out  1  converter can accept an operand (high only in IDLE)
binary  in  WIDTH  unsigned operand, sampled on accept
out_valid  out  1  bcd, blank and overflow are valid and stable
out_ready  in  1  consumer accepts the result
bcd  out  4*DIGITS  packed digits, digit i at bits [4i+3:4i], digit 0 = ones
blank  out  DIGITS  bit i set when digit i and all higher digits are zero; bit 0 is always 0
overflow  out  1  value did not fit in DIGITS digits; bcd holds the low digits only

Behaviour:
- Reset:
  - State goes to IDLE.
  - bcd = 0, blank = 0, overflow = 0, out_valid = 0, in_ready = 1 on the cycle after reset is sampled.
  - Reset mid-conversion discards the operand; no result is produced.
- IDLE:
  - in_ready = 1.
  - When in_valid is sampled high on a clock edge: load the shift register with binary, clear the BCD accumulator and the overflow flag, set count = WIDTH, and go to SHIFT.
- SHIFT (in_ready = 0, out_valid = 0):
  - Each cycle, first add 3 to every digit ≥ 5.
  - Then shift {BCD accumulator, shift register} left by 1, so the binary MSB enters digit 0 bit 0.
  - A 1 shifted out of the top digit's bit 3 sets overflow (sticky for this conversion).
  - Decrement count. The edge that performs the final (WIDTH-th) shift also moves the state to DONE.
- DONE:
  - out_valid = 1; bcd, blank and overflow are held constant.
  - When out_ready is high on an edge, go to IDLE.
  - Holding out_ready low stalls indefinitely with the outputs stable.
- Latency and throughput:
  - Accept at edge T; shifts occur at edges T+1..T+WIDTH; out_valid is high after edge T+WIDTH.
  - Minimum period between accepts is WIDTH+2 cycles, because in_ready is low during SHIFT and DONE.
- in_valid while not in IDLE is ignored. The operand is not re-sampled after accept, so changing binary mid-conversion has no effect.
- blank is computed from the final bcd and is registered or stable together with bcd. When overflow = 1, blank is all 0.
- Add-3 arithmetic is 4-bit; a digit ≥ 5 never exceeds 9 before the add, so the result fits in 4 bits.
- WIDTH = 1 is legal: one shift cycle.
- If DIGITS ≥ ceil(WIDTH·log10 2), overflow can never assert.
- Count register width is clog2(WIDTH+1).

Decomposition:
- Shared header/package:
  - State encodings IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - A clog2 constant function.
  - The BCD_ADJ_THRESHOLD = 5 and BCD_ADJ_ADD = 3 constants.
- One sub-module, bcd_digit_adj: a purely combinational 4-bit add-3-if-≥5 cell, instantiated DIGITS times by a generate loop. The FSM, counter, shift datapath, overflow and blank logic stay in the top module.

Test Plan:
- WIDTH=8, DIGITS=3, binary=255, out_ready=1 → out_valid asserts exactly 8 cycles after accept; bcd=2,5,5; blank=000; overflow=0.
- WIDTH=8, DIGITS=3, binary=0 then 7 → bcd=0,0,0 with blank=110; then bcd=0,0,7 with blank=110.
- WIDTH=8, DIGITS=2: binary=99 → bcd=9,9, overflow=0. binary=100 → overflow=1, low digits 0,0. binary=255 → overflow=1, low digits 5,5.
- WIDTH=16, DIGITS=5, binary=65535 then 40000 (the second held on in_valid during the first) → 6,5,5,3,5 after 16 cycles; in_ready stays low until DONE is consumed; then 4,0,0,0,0 with blank=00000.
- Backpressure: hold out_ready low for 5 cycles in DONE → out_valid stays 1, bcd is unchanged, in_ready=0; the result is released on the first out_ready=1 edge and in_ready=1 on the next cycle.
- Assert reset at shift 4 of a WIDTH=8 conversion → next cycle: IDLE, out_valid=0, bcd=0, overflow=0. No spurious result appears, and a fresh operand of 42 afterwards gives 0,4,2.
